scanline_fetch_arbiter: RTL

Shares the single-port frame-buffer memory between two requesters: the VGA scan-out path and the rasterizer pixel-write path. On every horizontal line boundary it prefetches the next active line into a ping-pong line buffer, and it grants rasterizer writes in the cycles the fetch leaves free. It sits between the horizontal/vertical sync timing generators, the frame-buffer RAM and the pipeline's final write stage.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_line_buffer.sv | 50 +++++
 rtl/scanline_fetch_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer fetch path.
//   H_ACTIVE / V_ACTIVE : visible pixels per line / visible lines
//   LINE_STRIDE         : frame-buffer words between consecutive lines
//   ADDR_W / DATA_W     : frame-buffer word address and pixel widths
//   state_t             : one-hot arbiter state encoding
//   line_base()         : first frame-buffer word of a given line
package fb_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int LINE_STRIDE = 640;
    localparam int ADDR_W      = 19;
    localparam int DATA_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_FETCH = 3'b010,
        ST_DRAIN = 3'b100
    } state_t;

    // y * 640 built from two shifts (512 + 128), so no multiplier is needed.
    function automatic int unsigned line_base(input logic [8:0] y);
        int unsigned yz;
        yz = {23'd0, y};
        return (yz << 9) + (yz << 7);
    endfunction

endpackage

// File: rtl/fb_line_buffer.sv
// Ping-pong line buffer: two banks of H_ACTIVE pixels.
//   clk, rst                 : clock, synchronous active-low reset (read register only)
//   wr_en/wr_bank/wr_col/wr_data : fetch-side write port
//   rd_bank/rd_col/rd_en     : display-side read address and enable
//   rd_data                  : registered pixel; zero when rd_en was low
module fb_line_buffer #(
    parameter int H_ACTIVE = 640,
    parameter int DATA_W   = 8,
    parameter int COL_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [COL_W-1:0]  rd_col,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data
);
    import fb_pkg::*;

    localparam int DEPTH = 2 * H_ACTIVE;
    localparam int AW    = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Bank 1 sits directly above bank 0 so no power-of-two padding is needed.
    function automatic logic [AW-1:0] slot(input logic bank, input logic [COL_W-1:0] col);
        return bank ? (AW'(H_ACTIVE) + AW'(col)) : AW'(col);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[slot(wr_bank, wr_col)] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[slot(rd_bank, rd_col)];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/scanline_fetch_arbiter.sv
// Arbitrates the single-port frame buffer between line prefetch (scan-out)
// and rasterizer writes, and serves the display from a ping-pong line buffer.
//   clk, rst                  : clock, synchronous active-low reset
//   line_start/line_valid/line_y : line boundary pulse, active flag, row to fetch
//   pix_col/pix_de/pix_data   : display column, enable, registered pixel out
//   wr_req/wr_addr/wr_data/wr_ack : rasterizer write request and same-cycle ack
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : frame-buffer port
//   fetch_overrun             : sticky, a line boundary arrived mid-fetch
module scanline_fetch_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic              line_valid,
    input  logic [8:0]        line_y,
    input  logic [9:0]        pix_col,
    input  logic              pix_de,
    output logic [DATA_W-1:0] pix_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fetch_overrun
);
    import fb_pkg::*;

    localparam int COL_W = 10;

    if (V_ACTIVE > 512) begin : g_v_active_range
        $error("V_ACTIVE does not fit the 9-bit line_y port");
    end

    state_t              state_q, state_d;
    logic [COL_W-1:0]    fcol_q, fcol_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                disp_bank_q, disp_bank_d;
    logic                overrun_q, overrun_d;
    logic                rd_issue;
    logic                rd_vld_p1;
    logic [COL_W-1:0]    rd_col_p1;
    logic                capture;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fcol_q      <= '0;
            disp_bank_q <= 1'b0;
            overrun_q   <= 1'b0;
            rd_vld_p1   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcol_q      <= fcol_d;
            disp_bank_q <= disp_bank_d;
            overrun_q   <= overrun_d;
            rd_vld_p1   <= rd_issue;
        end
    end

    always_ff @(posedge clk) begin
        base_q    <= base_d;
        rd_col_p1 <= fcol_q;
    end

    // Memory outputs are combinational from state so a write is granted with
    // zero latency; everything is held at zero while rst is asserted so no
    // strobe can leak out during reset.
    always_comb begin
        state_d     = state_q;
        fcol_d      = fcol_q;
        base_d      = base_q;
        disp_bank_d = disp_bank_q;
        overrun_d   = overrun_q;
        rd_issue    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wr_ack      = 1'b0;

        if (rst) begin
            if (line_start) begin
                // A boundary always wins: no access this cycle, and any fetch
                // still running is abandoned.
                disp_bank_d = ~disp_bank_q;
                if (state_q != ST_IDLE) begin
                    overrun_d = 1'b1;
                end
                if (line_valid) begin
                    base_d  = ADDR_W'(line_base(line_y));
                    fcol_d  = '0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (wr_req) begin
                            mem_en    = 1'b1;
                            mem_we    = 1'b1;
                            mem_addr  = wr_addr;
                            mem_wdata = wr_data;
                            wr_ack    = 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        mem_en   = 1'b1;
                        mem_addr = base_q + ADDR_W'(fcol_q);
                        rd_issue = 1'b1;
                        fcol_d   = fcol_q + COL_W'(1);
                        if (fcol_q == COL_W'(H_ACTIVE - 1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ---- stage p1: read data returns one cycle after issue ----
    // Data landing on a line boundary belongs to the abandoned fetch, so drop it.
    assign capture = rd_vld_p1 & ~line_start & rst;

    fb_line_buffer #(
        .H_ACTIVE (H_ACTIVE),
        .DATA_W   (DATA_W),
        .COL_W    (COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_bank (~disp_bank_q),
        .wr_col  (rd_col_p1),
        .wr_data (mem_rdata),
        .rd_bank (disp_bank_q),
        .rd_col  (pix_col),
        .rd_en   (pix_de),
        .rd_data (pix_data)
    );

    assign fetch_overrun = overrun_q;

endmodule
